// File: rtl/race_phase_sequencer.sv
// Race phase sequencer: idle -> countdown -> racing -> coasting -> done/failed.
// Tracks the saturating distance driven and all frame-paced transitions.
module race_phase_sequencer #(
   parameter int FRAMES_PER_SEC  = 60,
   parameter int COUNTDOWN_SECS  = 3,
   parameter int COAST_FRAMES    = 120,
   parameter int FINISH_DISTANCE = 10000,
   parameter int DISTANCE_MAX    = 12000
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        frame_start,
   input  logic        start_race,
   input  logic [7:0]  speed,
   input  logic [10:0] player_y,
   input  logic [10:0] finish_line_y,
   input  logic        fuel_empty,
   output logic [31:0] distance_drove,
   output logic [2:0]  race_state,
   output logic [1:0]  countdown_digit,
   output logic        freeze_scroll,
   output logic        race_won
);

   localparam int FC_W = $clog2(FRAMES_PER_SEC + 1);
   localparam int CC_W = $clog2(COAST_FRAMES + 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COUNTDOWN = 3'd1,
      RACING    = 3'd2,
      COASTING  = 3'd3,
      DONE      = 3'd4,
      FAILED    = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       dist_q, dist_d;
   logic [FC_W-1:0]   fcnt_q, fcnt_d;
   logic [CC_W-1:0]   ccnt_q, ccnt_d;
   logic [1:0]        digit_q, digit_d;
   logic              freeze_q, freeze_d;
   logic              won_q, won_d;

   logic [32:0]       dist_sum;
   logic [31:0]       dist_sat;
   logic              crossing;

   // 33-bit sum so the saturation compare can never be fooled by a wrap.
   assign dist_sum = {1'b0, dist_q} + 33'(speed);
   assign dist_sat = (dist_sum > 33'(DISTANCE_MAX)) ? 32'(DISTANCE_MAX) : dist_sum[31:0];
   assign crossing = (dist_q > 32'(FINISH_DISTANCE)) && (finish_line_y >= player_y);

   always_comb begin
      state_d = state_q;
      dist_d  = dist_q;
      fcnt_d  = fcnt_q;
      ccnt_d  = ccnt_q;
      digit_d = digit_q;
      won_d   = 1'b0;
      case (state_q)
         IDLE: begin
            dist_d  = '0;
            fcnt_d  = '0;
            ccnt_d  = '0;
            digit_d = '0;
            if (start_race) begin
               state_d = COUNTDOWN;
               digit_d = 2'(COUNTDOWN_SECS);
            end
         end
         COUNTDOWN: begin
            if (frame_start) begin
               if (fcnt_q == FC_W'(FRAMES_PER_SEC - 1)) begin
                  fcnt_d = '0;
                  if (digit_q <= 2'd1) begin
                     state_d = RACING;
                     digit_d = '0;
                  end else begin
                     digit_d = digit_q - 2'd1;
                  end
               end else begin
                  fcnt_d = fcnt_q + FC_W'(1);
               end
            end
         end
         RACING: begin
            // Crossing wins over fuel loss on the same frame.
            if (frame_start) begin
               if (crossing) begin
                  state_d = COASTING;
                  ccnt_d  = '0;
                  dist_d  = dist_sat;
               end else if (fuel_empty) begin
                  state_d = FAILED;
               end else begin
                  dist_d  = dist_sat;
               end
            end
         end
         COASTING: begin
            if (frame_start) begin
               dist_d = dist_sat;
               if (ccnt_q == CC_W'(COAST_FRAMES - 1)) begin
                  state_d = DONE;
                  won_d   = 1'b1;
                  ccnt_d  = '0;
               end else begin
                  ccnt_d  = ccnt_q + CC_W'(1);
               end
            end
         end
         DONE, FAILED: begin
            if (start_race) begin
               state_d = IDLE;
               dist_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
            dist_d  = '0;
            fcnt_d  = '0;
            ccnt_d  = '0;
            digit_d = '0;
         end
      endcase
      freeze_d = !((state_d == RACING) || (state_d == COASTING));
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q  <= IDLE;
         dist_q   <= '0;
         fcnt_q   <= '0;
         ccnt_q   <= '0;
         digit_q  <= '0;
         freeze_q <= 1'b1;
         won_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         dist_q   <= dist_d;
         fcnt_q   <= fcnt_d;
         ccnt_q   <= ccnt_d;
         digit_q  <= digit_d;
         freeze_q <= freeze_d;
         won_q    <= won_d;
      end
   end

   assign distance_drove  = dist_q;
   assign race_state      = state_q;
   assign countdown_digit = digit_q;
   assign freeze_scroll   = freeze_q;
   assign race_won        = won_q;

endmodule

// File: tb/tb_race_phase_sequencer.sv
// Directed bench for race_phase_sequencer: countdown, finish, saturation,
// fuel failure, same-frame priority and asynchronous reset.
module tb_race_phase_sequencer;

   logic        clk;
   logic        resetN;
   logic        frame_start;
   logic        start_race;
   logic [7:0]  speed;
   logic [10:0] player_y;
   logic [10:0] finish_line_y;
   logic        fuel_empty;
   logic [31:0] distance_drove;
   logic [2:0]  race_state;
   logic [1:0]  countdown_digit;
   logic        freeze_scroll;
   logic        race_won;

   int checks = 0;
   int errors = 0;

   race_phase_sequencer dut (
      .clk            (clk),
      .resetN         (resetN),
      .frame_start    (frame_start),
      .start_race     (start_race),
      .speed          (speed),
      .player_y       (player_y),
      .finish_line_y  (finish_line_y),
      .fuel_empty     (fuel_empty),
      .distance_drove (distance_drove),
      .race_state     (race_state),
      .countdown_digit(countdown_digit),
      .freeze_scroll  (freeze_scroll),
      .race_won       (race_won)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // All steps begin and end on a falling edge; outputs are sampled there.
   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_start = 1'b1;
         @(negedge clk);
         frame_start = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic pulse_start();
      start_race = 1'b1;
      @(negedge clk);
      start_race = 1'b0;
   endtask

   task automatic countdown_to_racing();
      pulse_start();
      chk("start_cd_state", race_state, 1);
      frames(180);
      chk("cd_racing_state", race_state, 2);
   endtask

   initial begin
      resetN = 1'b0; frame_start = 1'b0; start_race = 1'b0; speed = '0;
      player_y = 11'd300; finish_line_y = 11'd400; fuel_empty = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_state", race_state, 0);
      chk("rst_dist", distance_drove, 0);
      chk("rst_digit", countdown_digit, 0);
      chk("rst_freeze", freeze_scroll, 1);
      chk("rst_won", race_won, 0);
      resetN = 1'b1;

      // Stays idle without start_race, even with frames and speed
      speed = 8'd200;
      frames(3);
      chk("idle_hold_state", race_state, 0);
      chk("idle_hold_dist", distance_drove, 0);
      speed = '0;

      // Countdown 3,2,1 for 60 frames each
      pulse_start();
      chk("cd_state", race_state, 1);
      chk("cd_digit3_entry", countdown_digit, 3);
      chk("cd_freeze", freeze_scroll, 1);
      frames(59);
      chk("cd_digit3_f59", countdown_digit, 3);
      frames(1);
      chk("cd_digit2_f60", countdown_digit, 2);
      frames(59);
      chk("cd_digit2_f119", countdown_digit, 2);
      frames(1);
      chk("cd_digit1_f120", countdown_digit, 1);
      frames(59);
      chk("cd_state_f179", race_state, 1);
      chk("cd_freeze_f179", freeze_scroll, 1);
      frames(1);
      chk("race_state_f180", race_state, 2);
      chk("race_digit0", countdown_digit, 0);
      chk("race_freeze0", freeze_scroll, 0);

      // Finish: speed 200, crossing at the 52nd frame
      speed = 8'd200;
      frames(50);
      chk("race_dist_50", distance_drove, 10000);
      frames(1);
      chk("race_state_51", race_state, 2);
      chk("race_dist_51", distance_drove, 10200);
      @(negedge clk);
      chk("no_frame_hold", distance_drove, 10200);
      frames(1);
      chk("coast_state_52", race_state, 3);
      chk("coast_dist_52", distance_drove, 10400);

      // Fuel loss is ignored while coasting
      fuel_empty = 1'b1;
      frames(1);
      chk("coast_dist_acc", distance_drove, 10600);
      chk("coast_fuel_ignored", race_state, 3);
      frames(118);
      chk("coast_state_119", race_state, 3);
      chk("coast_won_119", race_won, 0);
      chk("coast_freeze", freeze_scroll, 0);
      fuel_empty = 1'b0;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      chk("done_state", race_state, 4);
      chk("done_won_pulse", race_won, 1);
      chk("done_dist_sat", distance_drove, 12000);
      chk("done_freeze", freeze_scroll, 1);
      @(negedge clk);
      chk("done_won_drop", race_won, 0);
      chk("done_hold_state", race_state, 4);

      pulse_start();
      chk("done_to_idle", race_state, 0);
      chk("done_to_idle_dist", distance_drove, 0);

      // Saturation at speed 255, no crossing
      speed = '0;
      countdown_to_racing();
      speed = 8'd255; finish_line_y = 11'd100;
      frames(47);
      chk("sat_dist_47", distance_drove, 11985);
      frames(1);
      chk("sat_dist_48", distance_drove, 12000);
      frames(12);
      chk("sat_dist_60", distance_drove, 12000);
      chk("sat_state", race_state, 2);
      speed = '0;
      frames(1);
      chk("speed0_hold", distance_drove, 12000);
      fuel_empty = 1'b1;
      frames(1);
      chk("sat_fail_state", race_state, 5);
      fuel_empty = 1'b0;
      pulse_start();
      chk("sat_fail_idle", race_state, 0);

      // Fuel loss at distance 5000
      countdown_to_racing();
      speed = 8'd200;
      frames(25);
      chk("fuel_dist_5000", distance_drove, 5000);
      speed = '0; fuel_empty = 1'b1;
      frames(1);
      chk("fail_state", race_state, 5);
      chk("fail_dist", distance_drove, 5000);
      chk("fail_freeze", freeze_scroll, 1);
      fuel_empty = 1'b0; speed = 8'd200;
      frames(2);
      chk("fail_dist_hold", distance_drove, 5000);
      pulse_start();
      chk("fail_to_idle", race_state, 0);
      chk("fail_to_idle_dist", distance_drove, 0);

      // Same-frame crossing and fuel loss, then async reset mid-coast
      speed = '0;
      countdown_to_racing();
      speed = 8'd200; finish_line_y = 11'd300; player_y = 11'd300;
      frames(51);
      chk("tie_pre_state", race_state, 2);
      fuel_empty = 1'b1;
      frames(1);
      chk("tie_coast", race_state, 3);
      chk("tie_dist", distance_drove, 10400);
      fuel_empty = 1'b0;
      frames(5);
      #2 resetN = 1'b0;
      #1;
      chk("async_rst_state", race_state, 0);
      chk("async_rst_dist", distance_drove, 0);
      chk("async_rst_digit", countdown_digit, 0);
      chk("async_rst_freeze", freeze_scroll, 1);
      chk("async_rst_won", race_won, 0);
      @(negedge clk);
      resetN = 1'b1;
      frames(2);
      chk("post_rst_idle", race_state, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
